// File: rtl/morse_pkg.sv
// Shared symbol codes, FSM state encoding and default timing for the Morse keyer.
package morse_pkg;

   localparam logic [1:0] SYM_DOT  = 2'b00;
   localparam logic [1:0] SYM_DASH = 2'b01;
   localparam logic [1:0] SYM_LGAP = 2'b10;
   localparam logic [1:0] SYM_WGAP = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2
   } state_t;

   localparam int DEF_DIV        = 4;
   localparam int DEF_DASH_UNITS = 3;
   localparam int DEF_LGAP_UNITS = 2;
   localparam int DEF_WGAP_UNITS = 6;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/morse_sym_fifo.sv
// Small symbol FIFO placed ahead of the keyer FSM when MORSE_KEYER_FIFO_EN is defined.
module morse_sym_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push, do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         // simultaneous push and pop leaves occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/morse_keyer.sv
// Morse element generator: symbols in over valid/ready, unit-timed keying on serial_out.
// Define MORSE_KEYER_FIFO_EN to buffer up to four symbols ahead of the FSM.
module morse_keyer
   import morse_pkg::*;
#(
   parameter int DIV        = DEF_DIV,
   parameter int DASH_UNITS = DEF_DASH_UNITS,
   parameter int LGAP_UNITS = DEF_LGAP_UNITS,
   parameter int WGAP_UNITS = DEF_WGAP_UNITS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sym_in,
   input  logic       sym_valid,
   output logic       sym_ready,
   output logic       serial_out,
   output logic       busy,
   output logic       unit_tick
);

   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int UNIT_W = $clog2(max3(DASH_UNITS, LGAP_UNITS, WGAP_UNITS) + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [UNIT_W-1:0] ONE_U    = UNIT_W'(1);
   localparam logic [UNIT_W-1:0] DASH_U   = UNIT_W'(DASH_UNITS);
   localparam logic [UNIT_W-1:0] LGAP_U   = UNIT_W'(LGAP_UNITS);
   localparam logic [UNIT_W-1:0] WGAP_U   = UNIT_W'(WGAP_UNITS);

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [UNIT_W-1:0] unit_cnt;
   logic              take;
   logic [1:0]        sym;
   logic              unit_end;

`ifdef MORSE_KEYER_FIFO_EN
   logic fifo_full, fifo_empty;

   morse_sym_fifo #(.DEPTH(4), .W(2)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (sym_valid),
      .push_data (sym_in),
      .pop       (take),
      .pop_data  (sym),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // the pop is the accept; a freshly pushed symbol waits one edge
   assign take      = (state == IDLE) && !fifo_empty;
   assign sym_ready = !fifo_full;
   assign busy      = (state != IDLE) || !fifo_empty;
`else
   assign take      = sym_valid && (state == IDLE);
   assign sym       = sym_in;
   assign sym_ready = (state == IDLE);
   assign busy      = (state != IDLE);
`endif

   assign unit_end  = (state != IDLE) && (div_cnt == DIV_LAST);
   assign unit_tick = unit_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         unit_cnt   <= '0;
         serial_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  div_cnt <= '0;
                  case (sym)
                     SYM_DOT:  begin state <= MARK;  unit_cnt <= ONE_U;  serial_out <= 1'b1; end
                     SYM_DASH: begin state <= MARK;  unit_cnt <= DASH_U; serial_out <= 1'b1; end
                     SYM_LGAP: begin state <= SPACE; unit_cnt <= LGAP_U; serial_out <= 1'b0; end
                     default:  begin state <= SPACE; unit_cnt <= WGAP_U; serial_out <= 1'b0; end
                  endcase
               end
            end
            MARK, SPACE: begin
               if (unit_end) begin
                  div_cnt <= '0;
                  if (unit_cnt == ONE_U) begin
                     // every mark is followed by a one-unit inter-element space
                     if (state == MARK) begin
                        state      <= SPACE;
                        unit_cnt   <= ONE_U;
                        serial_out <= 1'b0;
                     end else begin
                        state    <= IDLE;
                        unit_cnt <= '0;
                     end
                  end else begin
                     unit_cnt <= unit_cnt - 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               div_cnt    <= '0;
               unit_cnt   <= '0;
               serial_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: DIV=4 and DIV=1 instances against a timeline model.
module tb_morse_keyer;

   localparam logic [1:0] DOT  = 2'b00;
   localparam logic [1:0] DASH = 2'b01;
   localparam logic [1:0] LGAP = 2'b10;
   localparam logic [1:0] WGAP = 2'b11;
   localparam int DASH_U = 3;
   localparam int LGAP_U = 2;
   localparam int WGAP_U = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sym_in = 2'b00;
   logic       sym_valid = 1'b0;
   logic       sel = 1'b0;

   logic r4, s4, b4, t4, r1, s1, b1, t1;
   logic rdy, ser, bsy, tck;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   morse_keyer #(.DIV(4), .DASH_UNITS(DASH_U), .LGAP_UNITS(LGAP_U), .WGAP_UNITS(WGAP_U)) dut4 (
      .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid && !sel),
      .sym_ready(r4), .serial_out(s4), .busy(b4), .unit_tick(t4));

   morse_keyer #(.DIV(1), .DASH_UNITS(DASH_U), .LGAP_UNITS(LGAP_U), .WGAP_UNITS(WGAP_U)) dut1 (
      .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid && sel),
      .sym_ready(r1), .serial_out(s1), .busy(b1), .unit_tick(t1));

   assign rdy = sel ? r1 : r4;
   assign ser = sel ? s1 : s4;
   assign bsy = sel ? b1 : b4;
   assign tck = sel ? t1 : t4;

   function automatic int sym_len(input logic [1:0] s, input int div);
      case (s)
         DOT:     return 2 * div;
         DASH:    return (DASH_U + 1) * div;
         LGAP:    return LGAP_U * div;
         default: return WGAP_U * div;
      endcase
   endfunction

   function automatic int sym_mark(input logic [1:0] s, input int div);
      case (s)
         DOT:     return div;
         DASH:    return DASH_U * div;
         default: return 0;
      endcase
   endfunction

   // Period c is the clock period right after edge c; edge 0 is the first edge with valid up.
   task automatic run_stream(input string name, input bit use1, input logic [1:0] syms[$]);
      int div, n, idx, last, p, q, occ;
      int push_t[$], pop_t[$], len[$], mk[$], acc[$];
      logic rs, es, eb, er, et;
      div = use1 ? 1 : 4;
      n = syms.size();
      sel = use1;
      for (int i = 0; i < n; i++) begin
         len.push_back(sym_len(syms[i], div));
         mk.push_back(sym_mark(syms[i], div));
`ifdef MORSE_KEYER_FIFO_EN
         p = (i == 0) ? 0 : push_t[i-1] + 1;
         if (i >= 4 && pop_t[i-4] + 1 > p) p = pop_t[i-4] + 1;
         q = p + 1;
         if (i > 0 && pop_t[i-1] + len[i-1] + 1 > q) q = pop_t[i-1] + len[i-1] + 1;
`else
         p = (i == 0) ? 0 : pop_t[i-1] + len[i-1] + 1;
         q = p;
`endif
         push_t.push_back(p);
         pop_t.push_back(q);
      end
      last = pop_t[n-1] + len[n-1] + 3;

      @(negedge clk);
      idx = 0;
      sym_valid = 1'b1;
      sym_in = syms[0];
      for (int c = 0; c < last; c++) begin
         rs = rdy;
         @(posedge clk);
         if (sym_valid && rs) begin
            acc.push_back(c);
            idx++;
         end
         @(negedge clk);
         if (idx < n) sym_in = syms[idx];
         else sym_valid = 1'b0;

         es = 0; eb = 0; et = 0; er = 1;
         for (int j = 0; j < n; j++) begin
            if (c >= pop_t[j] && c < pop_t[j] + len[j]) begin
               eb = 1; er = 0;
               if (c - pop_t[j] < mk[j]) es = 1;
               if ((c - pop_t[j] + 1) % div == 0) et = 1;
            end
         end
`ifdef MORSE_KEYER_FIFO_EN
         occ = 0;
         for (int j = 0; j < n; j++) begin
            if (push_t[j] <= c) occ++;
            if (pop_t[j] <= c) occ--;
         end
         if (occ > 0) eb = 1;
         er = (occ < 4);
`endif
         total++;
         if (ser !== es) $display("FAIL %s serial_out c=%0d got %b exp %b", name, c, ser, es);
         else passed++;
         total++;
         if (bsy !== eb) $display("FAIL %s busy c=%0d got %b exp %b", name, c, bsy, eb);
         else passed++;
         total++;
         if (rdy !== er) $display("FAIL %s sym_ready c=%0d got %b exp %b", name, c, rdy, er);
         else passed++;
         total++;
         if (tck !== et) $display("FAIL %s unit_tick c=%0d got %b exp %b", name, c, tck, et);
         else passed++;
      end
      sym_valid = 1'b0;

      total++;
      if (acc.size() != n) $display("FAIL %s accept_count got %0d exp %0d", name, acc.size(), n);
      else begin
         passed++;
         for (int i = 0; i < n; i++) begin
            total++;
            if (acc[i] != push_t[i]) $display("FAIL %s accept_edge[%0d] got %0d exp %0d", name, i, acc[i], push_t[i]);
            else passed++;
         end
      end
   endtask

   task automatic test_reset();
      total++;
      if ({s4, r4, b4, t4, s1, r1, b1, t1} !== 8'b0100_0100)
         $display("FAIL reset outputs got %b exp %b", {s4, r4, b4, t4, s1, r1, b1, t1}, 8'b0100_0100);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({s4, r4, b4, t4} !== 4'b0100) $display("FAIL post_reset got %b exp 0100", {s4, r4, b4, t4});
      else passed++;
   endtask

   task automatic test_dot();
      logic [1:0] q[$];
      q.push_back(DOT);
      run_stream("dot_div4", 0, q);
   endtask

   task automatic test_dash();
      logic [1:0] q[$];
      q.push_back(DASH);
      run_stream("dash_div4", 0, q);
   endtask

   task automatic test_back_to_back();
      logic [1:0] q[$];
      q.push_back(LGAP);
      q.push_back(WGAP);
      run_stream("gaps_div4", 0, q);
   endtask

   task automatic test_div1();
      logic [1:0] q[$];
      q.push_back(DOT);
      q.push_back(DASH);
      q.push_back(DOT);
      run_stream("stream_div1", 1, q);
   endtask

   task automatic test_random();
      logic [1:0] q[$];
      for (int r = 0; r < 4; r++) begin
         q.delete();
         for (int i = 0; i < int'($urandom_range(3, 7)); i++) q.push_back(2'($urandom_range(0, 3)));
         run_stream((r % 2) ? "rand_div1" : "rand_div4", r % 2, q);
      end
   endtask

   task automatic test_fifo();
      logic [1:0] q[$];
      q.push_back(DOT);
      q.push_back(DASH);
      q.push_back(LGAP);
      q.push_back(DOT);
      q.push_back(WGAP);
      q.push_back(DASH);
      run_stream("fifo_fill", 0, q);
   endtask

   task automatic test_abort();
      sel = 1'b0;
      @(negedge clk);
      sym_valid = 1'b1;
      sym_in = DASH;
      @(negedge clk);
      sym_in = DOT;
      repeat (4) @(negedge clk);
      sym_valid = 1'b0;
      total++;
      if (s4 !== 1'b1) $display("FAIL abort_pre serial_out got %b exp 1", s4);
      else passed++;
      #2 rst = 1'b1;
      #1;
      total++;
      if (s4 !== 1'b0) $display("FAIL abort_async serial_out got %b exp 0", s4);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({r4, b4, s4} !== 3'b100) $display("FAIL abort_release ready/busy/serial got %b exp 100", {r4, b4, s4});
      else passed++;
      @(negedge clk);
      total++;
      if ({r4, b4, s4, t4} !== 4'b1000) $display("FAIL abort_idle ready/busy/serial/tick got %b exp 1000", {r4, b4, s4, t4});
      else passed++;
   endtask

   initial begin
      #1;
      test_reset();
      test_dot();
      test_dash();
      test_back_to_back();
      test_div1();
      test_random();
`ifdef MORSE_KEYER_FIFO_EN
      test_fifo();
`endif
      test_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
